regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter_if.sv | 37 +++
 rtl/regfile_write_arbiter.sv | 152 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request, register-file write port and scoreboard query bundle
// for the regfile write arbiter.
interface regfile_write_arbiter_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        write_enable;
    logic [4:0]  addr_rd;
    logic [31:0] data_rd;
    logic [4:0]  query_rs1;
    logic [4:0]  query_rs2;
    logic        busy_rs1;
    logic        busy_rs2;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        output query_rs1, query_rs2,
        input  alu_ready, ld_ready,
        input  write_enable, addr_rd, data_rd,
        input  busy_rs1, busy_rs2
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        input  query_rs1, query_rs2,
        output alu_ready, ld_ready,
        output write_enable, addr_rd, data_rd,
        output busy_rs1, busy_rs2
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter: per-requester write FIFOs,
// round-robin single write port, and a pending-write scoreboard for decode.
module regfile_write_arbiter #(
    parameter int unsigned DEPTH = 2
) (
    input logic                    clock,
    input logic                    reset_n,
    regfile_write_arbiter_if.slave bus
);
    localparam int unsigned NREQ   = 2;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    wr_entry_t         mem_q    [NREQ][DEPTH];
    wr_entry_t         mem_d    [NREQ][DEPTH];
    ptr_t              wr_ptr_q [NREQ];
    ptr_t              wr_ptr_d [NREQ];
    ptr_t              rd_ptr_q [NREQ];
    ptr_t              rd_ptr_d [NREQ];
    cnt_t              count_q  [NREQ];
    cnt_t              count_d  [NREQ];
    logic [NREQ-1:0]   ready_q, ready_d;
    logic              last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic [RD_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    wr_entry_t         push_entry [NREQ];
    logic [NREQ-1:0]   push_valid;
    logic [NREQ-1:0]   push;
    logic [NREQ-1:0]   nonempty;
    logic [NREQ-1:0]   grant;
    logic [NREG-1:0]   pending_c;

    // Queue push/pop, round-robin grant and write-port update.
    always_comb begin : next_state
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        ready_d      = ready_q;
        last_grant_d = last_grant_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;

        push_valid    = {bus.ld_valid, bus.alu_valid};
        push_entry[0] = wr_entry_t'{rd: bus.alu_rd, data: bus.alu_data};
        push_entry[1] = wr_entry_t'{rd: bus.ld_rd,  data: bus.ld_data};
        push          = '0;

        for (int r = 0; r < NREQ; r++) begin
            nonempty[r] = (count_q[r] != '0);
        end
        // last_grant_q == 1 means the load unit won last, so ALU has priority.
        grant[0] = nonempty[0] && (!nonempty[1] || last_grant_q);
        grant[1] = nonempty[1] && !grant[0];

        for (int r = 0; r < NREQ; r++) begin
            // Writes to x0 complete the handshake but never enter the queue.
            push[r] = push_valid[r] && ready_q[r] && (push_entry[r].rd != '0);
            if (push[r]) begin
                mem_d[r][wr_ptr_q[r]] = push_entry[r];
                wr_ptr_d[r]           = wr_ptr_q[r] + ptr_t'(1);
            end
            if (grant[r]) begin
                rd_ptr_d[r] = rd_ptr_q[r] + ptr_t'(1);
            end
            if (push[r] && !grant[r]) begin
                count_d[r] = count_q[r] + cnt_t'(1);
            end else if (!push[r] && grant[r]) begin
                count_d[r] = count_q[r] - cnt_t'(1);
            end
            ready_d[r] = (count_d[r] < cnt_t'(DEPTH));
        end

        if (grant[0]) begin
            we_d         = 1'b1;
            addr_d       = mem_q[0][rd_ptr_q[0]].rd;
            data_d       = mem_q[0][rd_ptr_q[0]].data;
            last_grant_d = 1'b0;
        end else if (grant[1]) begin
            we_d         = 1'b1;
            addr_d       = mem_q[1][rd_ptr_q[1]].rd;
            data_d       = mem_q[1][rd_ptr_q[1]].data;
            last_grant_d = 1'b1;
        end
    end

    // Scoreboard: every live queue entry plus the write currently on the port.
    always_comb begin : scoreboard
        ptr_t offset;
        offset    = '0;
        pending_c = '0;
        for (int r = 0; r < NREQ; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                offset = ptr_t'(i) - rd_ptr_q[r];
                if (cnt_t'(offset) < count_q[r]) begin
                    pending_c[mem_q[r][i].rd] = 1'b1;
                end
            end
        end
        if (we_q) begin
            pending_c[addr_q] = 1'b1;
        end
        pending_c[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '{default: '0};
            rd_ptr_q     <= '{default: '0};
            count_q      <= '{default: '0};
            ready_q      <= '0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ready_q      <= ready_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
        end
    end

    assign bus.alu_ready    = ready_q[0];
    assign bus.ld_ready     = ready_q[1];
    assign bus.write_enable = we_q;
    assign bus.addr_rd      = addr_q;
    assign bus.data_rd      = data_q;
    assign bus.busy_rs1     = pending_c[bus.query_rs1];
    assign bus.busy_rs2     = pending_c[bus.query_rs2];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a
// queue-based reference model.
module tb_regfile_write_arbiter;
    localparam int unsigned DEPTH = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter #(.DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q_alu[$];
    ent_t        q_ld[$];
    int          last_m;
    logic        ready_alu_m, ready_ld_m;
    logic        we_m;
    logic [4:0]  addr_m;
    logic [31:0] data_m;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_alu.delete();
        q_ld.delete();
        last_m      = 1;
        ready_alu_m = 1'b0;
        ready_ld_m  = 1'b0;
        we_m        = 1'b0;
        addr_m      = '0;
        data_m      = '0;
    endtask

    // One rising edge of the reference: pick a head by round-robin, then accept offers.
    task automatic model_edge();
        ent_t e;
        bit   ne_alu, ne_ld;
        if (!reset_n) return;
        ne_alu = (q_alu.size() != 0);
        ne_ld  = (q_ld.size() != 0);
        we_m   = 1'b0;
        if (ne_alu && (!ne_ld || last_m == 1)) begin
            e = q_alu.pop_front();
            we_m = 1'b1; addr_m = e.rd; data_m = e.data; last_m = 0;
        end else if (ne_ld) begin
            e = q_ld.pop_front();
            we_m = 1'b1; addr_m = e.rd; data_m = e.data; last_m = 1;
        end
        if (bus.alu_valid && ready_alu_m && bus.alu_rd != 0)
            q_alu.push_back('{rd: bus.alu_rd, data: bus.alu_data});
        if (bus.ld_valid && ready_ld_m && bus.ld_rd != 0)
            q_ld.push_back('{rd: bus.ld_rd, data: bus.ld_data});
        ready_alu_m = (q_alu.size() < DEPTH);
        ready_ld_m  = (q_ld.size() < DEPTH);
    endtask

    function automatic logic busy_m(input logic [4:0] q);
        if (q == 0) return 1'b0;
        if (we_m && addr_m == q) return 1'b1;
        foreach (q_alu[i]) if (q_alu[i].rd == q) return 1'b1;
        foreach (q_ld[i])  if (q_ld[i].rd == q)  return 1'b1;
        return 1'b0;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".we"},    32'(bus.write_enable), 32'(we_m));
        check({tag, ".addr"},  32'(bus.addr_rd),      32'(addr_m));
        check({tag, ".data"},  bus.data_rd,           data_m);
        check({tag, ".aready"}, 32'(bus.alu_ready),   32'(ready_alu_m));
        check({tag, ".lready"}, 32'(bus.ld_ready),    32'(ready_ld_m));
        check({tag, ".busy1"}, 32'(bus.busy_rs1),     32'(busy_m(bus.query_rs1)));
        check({tag, ".busy2"}, 32'(bus.busy_rs2),     32'(busy_m(bus.query_rs2)));
    endtask

    // Advance one clock and compare at the following falling edge.
    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        @(negedge clock);
        compare_all(tag);
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
        bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = adat;
        bus.ld_valid  = lv; bus.ld_rd  = lrd; bus.ld_data  = ldat;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Asynchronous reset away from the clock edge, then release at a falling edge.
    task automatic mid_reset(input string tag);
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all({tag, ".async"});
        idle();
        step({tag, ".held"});
        reset_n = 1'b1;
        step({tag, ".rel"});
        check({tag, ".ready_after"}, 32'(bus.alu_ready & bus.ld_ready), 32'd1);
    endtask

    initial begin
        model_reset();
        idle();
        bus.query_rs1 = 5'd0;
        bus.query_rs2 = 5'd0;
        #12;
        compare_all("reset");
        @(negedge clock);
        reset_n = 1'b1;
        step("first_edge");
        check("first_edge.ready", 32'(bus.alu_ready & bus.ld_ready), 32'd1);

        // Single write with scoreboard query.
        bus.query_rs1 = 5'd5;
        bus.query_rs2 = 5'd6;
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        step("single.push");
        check("single.busy_queued", 32'(bus.busy_rs1), 32'd1);
        idle();
        step("single.write");
        check("single.we", 32'(bus.write_enable), 32'd1);
        check("single.addr", 32'(bus.addr_rd), 32'd5);
        check("single.data", bus.data_rd, 32'hDEADBEEF);
        check("single.busy_writing", 32'(bus.busy_rs1), 32'd1);
        step("single.done");
        check("single.we_low", 32'(bus.write_enable), 32'd0);

        // Contention after reset: ALU first.
        mid_reset("rst1");
        bus.query_rs1 = 5'd3;
        bus.query_rs2 = 5'd4;
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        step("cont.push");
        idle();
        step("cont.w1");
        check("cont.first_rd", 32'(bus.addr_rd), 32'd3);
        step("cont.w2");
        check("cont.second_rd", 32'(bus.addr_rd), 32'd4);
        check("cont.second_data", bus.data_rd, 32'h22);
        step("cont.idle");

        // Both requesters saturate: FIFOs fill, readies drop, writes alternate.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'(8 + i), $urandom, 1'b1, 5'(16 + i), $urandom);
            step("rr");
        end
        idle();
        for (int i = 0; i < 6; i++) step("rr.drain");

        // x0 discard.
        bus.query_rs1 = 5'd0;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
        step("x0.push");
        idle();
        step("x0.after");
        check("x0.we", 32'(bus.write_enable), 32'd0);
        check("x0.busy", 32'(bus.busy_rs1), 32'd0);

        // Back-to-back stream of eight ALU writes.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 5'(i), 32'(i * 16), 1'b0, 5'd0, 32'd0);
            step("stream");
            check("stream.aready", 32'(bus.alu_ready), 32'd1);
        end
        idle();
        step("stream.tail");
        check("stream.last", 32'(bus.addr_rd), 32'd8);
        step("stream.end");

        // Reset with three entries queued.
        bus.query_rs1 = 5'd9;
        drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA);
        step("mid.fill1");
        drive(1'b1, 5'd11, 32'hBB, 1'b1, 5'd12, 32'hCC);
        step("mid.fill2");
        idle();
        mid_reset("rst2");
        for (int i = 0; i < 3; i++) begin
            step("mid.quiet");
            check("mid.no_write", 32'(bus.write_enable), 32'd0);
        end

        // Randomized traffic with small register numbers to exercise the scoreboard.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            bus.query_rs1 = 5'($urandom_range(0, 7));
            bus.query_rs2 = 5'($urandom_range(0, 7));
            step("rand");
            if (i == 200) mid_reset("rst3");
        end
        idle();
        for (int i = 0; i < 6; i++) step("rand.drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
